// File: rtl/audio_dac_serializer_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the DAC serializer slice: FSM state encoding,
// synchronizer depth and the bit positions of the left/right halves of a
// 32-bit stereo frame.
// ---------------------------------------------------------------------------
package audio_pkg;

    // Serializer FSM: IDLE until the first LRCK rise, then alternate slots.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_e;

    // Depth of the metastability synchronizer ahead of the history flop.
    localparam int SYNC_STAGES = 2;

    // Frame layout: {left[15:0], right[15:0]}.
    localparam int FRAME_W  = 32;
    localparam int LEFT_HI  = 31;
    localparam int LEFT_LO  = 16;
    localparam int RIGHT_HI = 15;
    localparam int RIGHT_LO = 0;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// ---------------------------------------------------------------------------
// audio_dac_serializer_if
// Valid/ready frame bus from the filter (master) into the serializer's
// one-frame holding buffer (slave).
//   audioIn  : stereo frame {left[15:0], right[15:0]}
//   in_valid : producer has a frame on audioIn
//   in_ready : holding buffer empty, frame accepted when valid && ready
// ---------------------------------------------------------------------------
interface audio_dac_serializer_if;
    import audio_pkg::*;

    logic [FRAME_W-1:0] audioIn;
    logic               in_valid;
    logic               in_ready;

    modport master (output audioIn, output in_valid, input in_ready);
    modport slave  (input audioIn, input in_valid, output in_ready);

endinterface

// File: rtl/audio_dac_serializer_clk_edge_sync.sv
// ---------------------------------------------------------------------------
// clk_edge_sync
// Brings an asynchronous codec clock into the clk domain and produces
// one-clk rise/fall pulses.
//   clk, rst : system clock, synchronous active-high reset
//   async_i  : asynchronous input pin
//   rise_o   : one-clk pulse after a 0->1 transition on async_i
//   fall_o   : one-clk pulse after a 1->0 transition on async_i
// ---------------------------------------------------------------------------
module clk_edge_sync
    import audio_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [1:0] ARMED = 2'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [1:0]             armCnt_q;

    // Synchronizer chain plus history flop. The chain is cleared by reset,
    // so pulses stay gated until the history flop holds a real pin sample;
    // otherwise a pin already high at reset release would look like a fresh
    // edge and start the serializer mid-slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            armCnt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            if (armCnt_q != ARMED) begin
                armCnt_q <= armCnt_q + 1'b1;
            end
        end
    end

    assign rise_o = (armCnt_q == ARMED) &&  sync_q[SYNC_STAGES-1] && !hist_q;
    assign fall_o = (armCnt_q == ARMED) && !sync_q[SYNC_STAGES-1] &&  hist_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// ---------------------------------------------------------------------------
// audio_dac_serializer
// Left-justified serializer for the WM8731 DAC. Frames arrive through a
// one-deep holding buffer and are shifted out MSB first on AUD_DACDAT,
// framed by the codec-mastered AUD_BCLK / AUD_DACLRCK.
//   clk, rst       : system clock (>= 8x BCLK), synchronous active-high reset
//   AUD_BCLK       : codec bit clock (async)
//   AUD_DACLRCK    : codec frame clock, high = left slot (async)
//   bus            : valid/ready frame input (slave modport)
//   AUD_DACDAT     : serial data to the codec
//   locked         : first frame start since reset has been seen
//   underrun       : one-clk pulse when a frame start finds the buffer empty
//   underrun_count : saturating count of underruns
// ---------------------------------------------------------------------------
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    audio_dac_serializer_if.slave bus,
    output logic                  AUD_DACDAT,
    output logic                  locked,
    output logic                  underrun,
    output logic [CNT_W-1:0]      underrun_count
);

    localparam int               BC_W   = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0]  BC_MAX = BC_W'(WIDTH);

    logic lrRise, lrFall, bclkFall, unusedBclkRise;

    state_e             state_q;
    logic               bufFull_q;
    logic [FRAME_W-1:0] buffer_q;
    logic [FRAME_W-1:0] frame_q;
    logic [WIDTH-1:0]   shiftReg_q;
    logic [BC_W-1:0]    bitCnt_q;
    logic               locked_q;
    logic               underrun_q;
    logic [CNT_W-1:0]   underrunCnt_q;

    logic [FRAME_W-1:0] frameNext;
    logic               accept;
    logic               loadFrame;
    logic               loadRight;
    logic               doShift;

    clk_edge_sync uBclkSync (
        .clk     (clk),
        .rst     (rst),
        .async_i (AUD_BCLK),
        .rise_o  (unusedBclkRise),
        .fall_o  (bclkFall)
    );

    clk_edge_sync uLrckSync (
        .clk     (clk),
        .rst     (rst),
        .async_i (AUD_DACLRCK),
        .rise_o  (lrRise),
        .fall_o  (lrFall)
    );

    // A buffered frame replaces the current one at frame start; with an
    // empty buffer the last frame simply repeats.
    assign frameNext = bufFull_q ? buffer_q : frame_q;
    assign accept    = bus.in_valid && !bufFull_q;
    assign loadFrame = lrRise && (state_q == IDLE || state_q == RIGHT);
    assign loadRight = lrFall && (state_q == LEFT);
    // Any LRCK edge in the same clk suppresses the shift so a freshly loaded
    // MSB is never skipped.
    assign doShift   = bclkFall && !lrRise && !lrFall && (state_q != IDLE);

    // Main FSM and datapath. Accept only happens while the buffer is empty and
    // frame load only drains it while full, so the two never touch bufFull_q
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bufFull_q     <= 1'b0;
            buffer_q      <= '0;
            frame_q       <= '0;
            shiftReg_q    <= '0;
            bitCnt_q      <= '0;
            locked_q      <= 1'b0;
            underrun_q    <= 1'b0;
            underrunCnt_q <= '0;
        end else begin
            underrun_q <= 1'b0;

            if (accept) begin
                buffer_q  <= bus.audioIn;
                bufFull_q <= 1'b1;
            end

            if (loadFrame) begin
                frame_q    <= frameNext;
                shiftReg_q <= frameNext[LEFT_HI:LEFT_LO];
                bitCnt_q   <= '0;
                state_q    <= LEFT;
                locked_q   <= 1'b1;
                if (bufFull_q) begin
                    bufFull_q <= 1'b0;
                end else begin
                    underrun_q <= 1'b1;
                    if (underrunCnt_q != '1) begin
                        underrunCnt_q <= underrunCnt_q + 1'b1;
                    end
                end
            end else if (loadRight) begin
                shiftReg_q <= frame_q[RIGHT_HI:RIGHT_LO];
                bitCnt_q   <= '0;
                state_q    <= RIGHT;
            end else if (doShift) begin
                shiftReg_q <= {shiftReg_q[WIDTH-2:0], 1'b0};
                if (bitCnt_q != BC_MAX) begin
                    bitCnt_q <= bitCnt_q + 1'b1;
                end
            end
        end
    end

    // Past WIDTH bits the slot is padded with zeros; in IDLE the shift
    // register is cleared so the line stays low.
    assign AUD_DACDAT     = (bitCnt_q < BC_MAX) ? shiftReg_q[WIDTH-1] : 1'b0;
    assign bus.in_ready   = !bufFull_q;
    assign locked         = locked_q;
    assign underrun       = underrun_q;
    assign underrun_count = underrunCnt_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// ---------------------------------------------------------------------------
// tb_audio_dac_serializer
// Drives a behavioural codec (BCLK/LRCK, left-justified, 16 clk per BCLK)
// and a valid/ready producer, and compares every captured slot with a
// frame-level reference model (queue of accepted frames, saturating
// underrun count).
// ---------------------------------------------------------------------------
module tb_audio_dac_serializer;

    localparam int CNT_W = 4;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             bclk = 1'b1;
    logic             lrck = 1'b0;
    logic             dacdat;
    logic             locked;
    logic             underrun;
    logic [CNT_W-1:0] ucount;

    audio_dac_serializer_if bus ();

    audio_dac_serializer #(
        .WIDTH (16),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .AUD_BCLK       (bclk),
        .AUD_DACLRCK    (lrck),
        .bus            (bus),
        .AUD_DACDAT     (dacdat),
        .locked         (locked),
        .underrun       (underrun),
        .underrun_count (ucount)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    int          checks     = 0;
    int          errors     = 0;
    int          pulseCount = 0;
    int          expPulses  = 0;
    int          expCount   = 0;
    logic        lockedExp  = 1'b0;
    logic [31:0] curFrame   = '0;
    logic [31:0] modelQ[$];

    // Count every underrun pulse seen on the output.
    always @(negedge clk) begin
        if (underrun === 1'b1) pulseCount++;
    end

    // Hard stop so the run can never hang.
    initial begin
        #(20 * 200000);
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected serial pattern of one slot of n BCLKs: channel MSB first,
    // zeros after 16 bits, and zeros from bit 'cut' on when reset hits.
    function automatic logic [31:0] slotBits(input logic [15:0] ch, input int n, input int cut);
        logic [31:0] v = '0;
        logic        b;
        for (int k = 0; k < n; k++) begin
            b = (k < 16 && (cut < 0 || k < cut)) ? ch[15-k] : 1'b0;
            v = {v[30:0], b};
        end
        return v;
    endfunction

    // Offer one frame on the valid/ready bus and wait (bounded) for accept.
    task automatic applyStimulus(input logic [31:0] data);
        int waitCnt = 0;
        bit done    = 0;
        @(negedge clk);
        bus.audioIn  = data;
        bus.in_valid = 1'b1;
        while (!done && waitCnt < 4000) begin
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
                waitCnt++;
            end
        end
        checkOutput("acceptDone", 32'(done), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (done) modelQ.push_back(data);
    endtask

    // One codec slot: LRCK changes with the first BCLK fall, data is sampled
    // on each BCLK rise. Optionally pulses reset during bit rstBit.
    task automatic runSlot(input logic lr, input int n, input int rstBit, output logic [31:0] cap);
        cap = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (k == 0) lrck = lr;
            for (int j = 0; j < 7; j++) begin
                @(negedge clk);
                if (k == rstBit && j == 0) rst = 1'b1;
                if (k == rstBit && j == 1) begin
                    rst = 1'b0;
                    checkOutput("dacdatAfterReset", 32'(dacdat), 32'd0);
                    checkOutput("lockedAfterReset", 32'(locked), 32'd0);
                    checkOutput("countAfterReset", 32'(ucount), 32'd0);
                end
            end
            @(negedge clk);
            bclk = 1'b1;
            cap = {cap[30:0], dacdat};
            repeat (7) @(negedge clk);
        end
    endtask

    // One stereo frame against the reference model.
    task automatic runFrame(input int ln, input int rn, input int rstBit);
        logic [31:0] cap;
        if (modelQ.size() > 0) begin
            curFrame = modelQ.pop_front();
        end else begin
            expPulses++;
            if (expCount < (1 << CNT_W) - 1) expCount++;
        end
        lockedExp = 1'b1;
        runSlot(1'b1, ln, rstBit, cap);
        checkOutput("leftSlot", cap, slotBits(curFrame[31:16], ln, rstBit));
        if (rstBit >= 0) begin
            modelQ.delete();
            curFrame  = '0;
            expCount  = 0;
            lockedExp = 1'b0;
            runSlot(1'b0, rn, -1, cap);
            checkOutput("rightSlotIdle", cap, slotBits(16'h0000, rn, -1));
        end else begin
            runSlot(1'b0, rn, -1, cap);
            checkOutput("rightSlot", cap, slotBits(curFrame[15:0], rn, -1));
        end
        checkOutput("locked", 32'(locked), 32'(lockedExp));
        checkOutput("underrunCount", 32'(ucount), 32'(expCount));
        checkOutput("underrunPulses", pulseCount, expPulses);
    endtask

    initial begin
        bus.audioIn  = '0;
        bus.in_valid = 1'b0;

        // Reset values.
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("resetDacdat", 32'(dacdat), 32'd0);
        checkOutput("resetReady", 32'(bus.in_ready), 32'd1);
        checkOutput("resetLocked", 32'(locked), 32'd0);
        checkOutput("resetUnderrun", 32'(underrun), 32'd0);
        checkOutput("resetCount", 32'(ucount), 32'd0);
        repeat (4) @(negedge clk);

        // Normal transfer.
        applyStimulus(32'hA5A5_0F0F);
        checkOutput("readyLowWhenFull", 32'(bus.in_ready), 32'(modelQ.size() == 0));
        runFrame(32, 32, -1);

        // Underrun: one real frame, then nothing.
        applyStimulus(32'h1234_5678);
        runFrame(32, 32, -1);
        runFrame(32, 32, -1);

        // Backpressure: second frame waits for the next frame start.
        applyStimulus(32'h1111_2222);
        checkOutput("bpReadyLow", 32'(bus.in_ready), 32'(modelQ.size() == 0));
        fork
            applyStimulus(32'h3333_4444);
            runFrame(32, 32, -1);
        join
        checkOutput("bpReadyLow2", 32'(bus.in_ready), 32'(modelQ.size() == 0));
        runFrame(32, 32, -1);

        // Short slots, then a full frame must start cleanly at its MSB.
        applyStimulus($urandom());
        runFrame(12, 12, -1);
        applyStimulus($urandom());
        runFrame(32, 32, -1);

        // Reset during left bit 7.
        applyStimulus($urandom());
        runFrame(32, 32, 7);
        applyStimulus($urandom());
        runFrame(32, 32, -1);

        // Randomized frames, slot lengths and producer gaps.
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) applyStimulus($urandom());
            runFrame(int'($urandom_range(10, 32)), int'($urandom_range(10, 32)), -1);
        end

        // Saturation: 20 starved frames after a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelQ.delete();
        curFrame  = '0;
        expCount  = 0;
        lockedExp = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            runFrame(8, 8, -1);
        end
        checkOutput("satCount", 32'(ucount), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
